int_req_ctrl: RTL

Interrupt request side of the break/return protocol: latches three external interrupt lines, arbitrates them by fixed priority against the in-service level, and raises a one-cycle break request with a 2-bit interrupt code and the captured resume PC. It feeds the interrupt controller's break and code inputs. It consumes that controller's interrupt-enable and one-hot clear outputs, so nesting, masking and return bookkeeping live here.

---
 rtl/int_req_ctrl_if.sv | 33 +++
 rtl/int_req_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/int_req_ctrl_if.sv
// ============================================================================
// Module      : int_req_ctrl_if
// Description : Request/break bundle between interrupt sources, the pipeline
//               and the interrupt request controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface int_req_ctrl_if;
  logic [2:0]  in_IRQ;
  logic [2:0]  in_MASK;
  logic        in_NIE;
  logic [3:0]  in_IG;
  logic        in_STALL;
  logic [31:0] in_PC;
  logic        out_BK;
  logic [1:0]  out_code;
  logic [31:0] out_EPC;
  logic [2:0]  out_pending;
  logic [2:0]  out_ISR;

  modport master (
    output in_IRQ, in_MASK, in_NIE, in_IG, in_STALL, in_PC,
    input  out_BK, out_code, out_EPC, out_pending, out_ISR
  );

  modport slave (
    input  in_IRQ, in_MASK, in_NIE, in_IG, in_STALL, in_PC,
    output out_BK, out_code, out_EPC, out_pending, out_ISR
  );
endinterface

`default_nettype wire

// File: rtl/int_req_ctrl.sv
// ============================================================================
// Module      : int_req_ctrl
// Description : Latches three interrupt lines, arbitrates them by fixed
//               priority against the in-service level and issues break requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_req_ctrl (
  input  wire logic      in_CLK,
  input  wire logic      in_RST,
  int_req_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_irq_d;
  logic [2:0]  r_pend;
  logic [2:0]  r_isr;
  logic        r_bk;
  logic [1:0]  r_code;
  logic [31:0] r_epc;

  logic [2:0]  w_rise;
  logic [2:0]  w_elig;
  logic [1:0]  w_level;
  logic [1:0]  w_cand;
  logic        w_take;
  logic [2:0]  w_take_oh;
  logic        w_bk_nxt;
  logic [1:0]  w_code_nxt;
  logic [31:0] w_epc_nxt;
  logic        w_unused_ig;

  // Bit 3 of the controller's clear vector has no matching source.
  assign w_unused_ig = bus.in_IG[3];

  assign w_rise = bus.in_IRQ & ~r_irq_d;
  assign w_elig = r_pend & ~bus.in_MASK;

  always_comb begin
    w_level = 2'd0;
    if      (r_isr[2]) w_level = 2'd3;
    else if (r_isr[1]) w_level = 2'd2;
    else if (r_isr[0]) w_level = 2'd1;
  end

  always_comb begin
    w_cand = 2'd0;
    if      (w_elig[2]) w_cand = 2'd3;
    else if (w_elig[1]) w_cand = 2'd2;
    else if (w_elig[0]) w_cand = 2'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_bk_nxt    = 1'b0;
    w_code_nxt  = r_code;
    w_epc_nxt   = r_epc;
    case (r_state)
      ST_IDLE: begin
        if ((w_cand != 2'd0) && (w_cand > w_level) && bus.in_NIE && !bus.in_STALL) begin
          w_take      = 1'b1;
          w_state_nxt = ST_FIRE;
          w_bk_nxt    = 1'b1;
          w_code_nxt  = w_cand;
          w_epc_nxt   = bus.in_PC;
        end
      end
      ST_FIRE: w_state_nxt = ST_COOL;
      ST_COOL: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_take_oh = 3'b000;
    if (w_take) begin
      case (w_cand)
        2'd1:    w_take_oh = 3'b001;
        2'd2:    w_take_oh = 3'b010;
        2'd3:    w_take_oh = 3'b100;
        default: w_take_oh = 3'b000;
      endcase
    end
  end

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      r_state <= ST_IDLE;
      r_irq_d <= 3'b000;
      r_pend  <= 3'b000;
      r_isr   <= 3'b000;
      r_bk    <= 1'b0;
      r_code  <= 2'd0;
      r_epc   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_irq_d <= bus.in_IRQ;
      // A rise coinciding with the take re-arms the line as a fresh request.
      r_pend  <= (r_pend & ~w_take_oh) | w_rise;
      r_isr   <= (r_isr & ~bus.in_IG[2:0]) | w_take_oh;
      r_bk    <= w_bk_nxt;
      r_code  <= w_code_nxt;
      r_epc   <= w_epc_nxt;
    end
  end

  assign bus.out_BK      = r_bk;
  assign bus.out_code    = r_code;
  assign bus.out_EPC     = r_epc;
  assign bus.out_pending = r_pend;
  assign bus.out_ISR     = r_isr;

endmodule

`default_nettype wire
